// File: rtl/sobel_window_filter_pkg.sv
// Shared constants, types and tap arithmetic for the streaming 3x3 Sobel stage.
package sobel_window_filter_pkg;

  localparam int WIDTH  = 640;
  localparam int DATA_W = 12;
  localparam int OUT_W  = 15;
  localparam int COL_W  = $clog2(WIDTH);

  typedef logic        [DATA_W-1:0] pix_t;
  typedef logic        [DATA_W+1:0] tap_t;
  typedef logic signed [OUT_W-1:0]  grad_t;

  // a + 2b + c for one side of a Sobel kernel; 14 bits hold 4*(2^12-1).
  function automatic tap_t tap_sum(input pix_t a, input pix_t b, input pix_t c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic grad_t grad_diff(input tap_t pos, input tap_t neg);
    return $signed({1'b0, pos}) - $signed({1'b0, neg});
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port row buffer: synchronous read, read-before-write, contents not reset.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int DW    = 12
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_filter.sv
// Streaming 3x3 Sobel stage: two row buffers, 3x3 window, registered Gx/Gy.
// Valid-only stream: a pixel is taken on every clock with iDVAL=1, oDVAL pulses once per taken pixel two clocks later; there is no backpressure.
module sobel_window_filter
  import sobel_window_filter_pkg::*;
(
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [DATA_W-1:0]        iDATA,
  input  logic                     iDVAL,
  output logic signed [OUT_W-1:0]  oSOBEL_X,
  output logic signed [OUT_W-1:0]  oSOBEL_Y,
  output logic                     oDVAL
);

  logic [COL_W-1:0] col;
  logic [1:0]       rows_seen;
  logic             row_par;
  logic             col_last;

  assign col_last = (col == COL_W'(WIDTH - 1));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      col       <= '0;
      rows_seen <= '0;
      row_par   <= 1'b0;
    end else if (iDVAL) begin
      if (col_last) begin
        col     <= '0;
        row_par <= ~row_par;
        if (rows_seen != 2'd2) rows_seen <= rows_seen + 2'd1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // The two RAMs ping-pong by row parity: the one being written still returns
  // the row before last (read-before-write), the other returns the previous row.
  // This is the LB2 <= LB1, LB1 <= pixel shift without a read-modify-write chain.
  pix_t rd_a, rd_b;

  sobel_line_buffer #(.DEPTH(WIDTH), .DW(DATA_W)) u_lb_a (
    .clk   (iCLK),
    .en    (iDVAL),
    .we    (iDVAL & ~row_par),
    .addr  (col),
    .wdata (iDATA),
    .rdata (rd_a)
  );

  sobel_line_buffer #(.DEPTH(WIDTH), .DW(DATA_W)) u_lb_b (
    .clk   (iCLK),
    .en    (iDVAL),
    .we    (iDVAL & row_par),
    .addr  (col),
    .wdata (iDATA),
    .rdata (rd_b)
  );

  logic s0_valid, s0_first, s0_use1, s0_use2, s0_par;
  pix_t s0_pix;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s0_valid <= 1'b0;
      s0_pix   <= '0;
      s0_first <= 1'b0;
      s0_use1  <= 1'b0;
      s0_use2  <= 1'b0;
      s0_par   <= 1'b0;
    end else begin
      s0_valid <= iDVAL;
      if (iDVAL) begin
        s0_pix   <= iDATA;
        s0_first <= (col == '0);
        s0_use1  <= (rows_seen != 2'd0);
        s0_use2  <= (rows_seen == 2'd2);
        s0_par   <= row_par;
      end
    end
  end

  pix_t lb1, lb2;

  always_comb begin
    lb1 = '0;
    lb2 = '0;
    if (s0_use1) lb1 = s0_par ? rd_a : rd_b;
    if (s0_use2) lb2 = s0_par ? rd_b : rd_a;
  end

  pix_t w [3][3];
  logic s1_valid;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s1_valid <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= s0_first ? '0 : w[r][1];
          w[r][1] <= s0_first ? '0 : w[r][2];
        end
        w[0][2] <= lb2;
        w[1][2] <= lb1;
        w[2][2] <= s0_pix;
      end
    end
  end

  grad_t gx, gy;

  always_comb begin
    gx = grad_diff(tap_sum(w[0][2], w[1][2], w[2][2]),
                   tap_sum(w[0][0], w[1][0], w[2][0]));
    gy = grad_diff(tap_sum(w[2][0], w[2][1], w[2][2]),
                   tap_sum(w[0][0], w[0][1], w[0][2]));
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL    <= 1'b0;
      oSOBEL_X <= '0;
      oSOBEL_Y <= '0;
    end else begin
      oDVAL <= s1_valid;
      if (s1_valid) begin
        oSOBEL_X <= gx;
        oSOBEL_Y <= gy;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed bench for sobel_window_filter: hand-computed gradients at chosen pixels.
module tb_sobel_window_filter;
  import sobel_window_filter_pkg::*;

  localparam int K_U200  = 0;
  localparam int K_U100  = 1;
  localparam int K_VERT  = 2;
  localparam int K_HORIZ = 3;

  logic                    iCLK = 1'b0;
  logic                    iRST = 1'b0;
  logic [DATA_W-1:0]       iDATA = '0;
  logic                    iDVAL = 1'b0;
  logic signed [OUT_W-1:0] oSOBEL_X;
  logic signed [OUT_W-1:0] oSOBEL_Y;
  logic                    oDVAL;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_err = 0;
  logic [31:0] exp_q[$];
  int got_x[$], got_y[$], ref_x[$], ref_y[$];

  sobel_window_filter dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iDATA    (iDATA),
    .iDVAL    (iDVAL),
    .oSOBEL_X (oSOBEL_X),
    .oSOBEL_Y (oSOBEL_Y),
    .oDVAL    (oDVAL)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // scoreboard: capture outputs and match each against its expected arrival cycle
  always @(negedge iCLK) begin
    if (oDVAL === 1'b1) begin
      got_x.push_back(int'(oSOBEL_X));
      got_y.push_back(int'(oSOBEL_Y));
      if (exp_q.size() == 0) lat_err++;
      else if (exp_q.pop_front() != 32'(cyc)) lat_err++;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      K_U200:  return 200;
      K_U100:  return 100;
      K_VERT:  return (c < 320) ? 0 : 200;
      default: return (r < 2) ? 255 : 0;
    endcase
  endfunction

  function automatic int idx(input int r, input int c);
    return r * WIDTH + c;
  endfunction

  // drivers: all input changes happen just after a falling edge
  task automatic drive_pixel(input int v);
    iDATA = DATA_W'(v);
    iDVAL = 1'b1;
    exp_q.push_back(32'(cyc + 3));
    @(negedge iCLK);
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic restart();
    iDVAL = 1'b0;
    iRST  = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    exp_q.delete();
    got_x.delete();
    got_y.delete();
    lat_err = 0;
  endtask

  task automatic run_frame(input string name, input int kind, input int rows,
                           input bit gaps);
    int n;
    restart();
    n = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        drive_pixel(pix(kind, r, c));
        if (gaps && (n % 7 == 6)) idle(3);
        n++;
      end
    end
    idle(6);
    check({name, "_count"}, got_x.size(), rows * WIDTH);
    check({name, "_latency"}, lat_err, 0);
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int mism;

    // reset held for five cycles
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    check("reset_dval", oDVAL, 0);
    check("reset_x", oSOBEL_X, 0);
    check("reset_y", oSOBEL_Y, 0);

    // uniform 200
    run_frame("u200", K_U200, 4, 1'b0);
    check("u200_r0c5_x", got_x[idx(0, 5)], 0);
    check("u200_r0c5_y", got_y[idx(0, 5)], 800);
    check("u200_r1c0_x", got_x[idx(1, 0)], 600);
    check("u200_r1c0_y", got_y[idx(1, 0)], 200);
    check("u200_r2c2_x", got_x[idx(2, 2)], 0);
    check("u200_r2c2_y", got_y[idx(2, 2)], 0);
    check("u200_r3c639_x", got_x[idx(3, 639)], 0);
    check("u200_r3c639_y", got_y[idx(3, 639)], 0);

    // left-edge padding
    run_frame("u100", K_U100, 4, 1'b0);
    check("pad_c0_x", got_x[idx(3, 0)], 400);
    check("pad_c1_x", got_x[idx(3, 1)], 400);
    check("pad_c2_x", got_x[idx(3, 2)], 0);
    check("pad_c0_y", got_y[idx(3, 0)], 0);
    check("pad_c1_y", got_y[idx(3, 1)], 0);
    check("pad_c2_y", got_y[idx(3, 2)], 0);

    // vertical edge, gapless
    run_frame("vert", K_VERT, 4, 1'b0);
    check("vert_c320_x", got_x[idx(3, 320)], 800);
    check("vert_c321_x", got_x[idx(3, 321)], 800);
    check("vert_c322_x", got_x[idx(3, 322)], 0);
    check("vert_c320_y", got_y[idx(3, 320)], 0);
    check("vert_c321_y", got_y[idx(3, 321)], 0);
    check("vert_c322_y", got_y[idx(3, 322)], 0);
    ref_x = got_x;
    ref_y = got_y;

    // horizontal edge
    run_frame("horiz", K_HORIZ, 5, 1'b0);
    check("horiz_r2_y", got_y[idx(2, 10)], -1020);
    check("horiz_r3_y", got_y[idx(3, 10)], -1020);
    check("horiz_r4_y", got_y[idx(4, 10)], 0);
    check("horiz_r2_x", got_x[idx(2, 10)], 0);
    check("horiz_r3_x", got_x[idx(3, 10)], 0);
    check("horiz_r4_x", got_x[idx(4, 10)], 0);

    // vertical edge with 3-cycle gaps every 7 pixels
    run_frame("gaps", K_VERT, 4, 1'b1);
    check("gaps_c320_x", got_x[idx(3, 320)], 800);
    mism = 0;
    for (int i = 0; i < ref_x.size() && i < got_x.size(); i++)
      if (got_x[i] != ref_x[i] || got_y[i] != ref_y[i]) mism++;
    check("gaps_seq", mism, 0);

    // asynchronous reset in the middle of a row
    restart();
    for (int i = 0; i < 20; i++) drive_pixel(200);
    @(posedge iCLK);
    #1;
    check("pre_rst_dval", oDVAL, 1);
    #1;
    iRST = 1'b0;
    #1;
    check("async_rst_dval", oDVAL, 0);
    check("async_rst_x", oSOBEL_X, 0);
    check("async_rst_y", oSOBEL_Y, 0);
    iDVAL = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    got_x.delete();
    got_y.delete();
    lat_err = 0;
    for (int i = 0; i < 3; i++) drive_pixel(200);
    idle(6);
    check("post_rst_count", got_x.size(), 3);
    check("post_rst_latency", lat_err, 0);
    check("post_rst_c0_x", got_x[0], 200);
    check("post_rst_c0_y", got_y[0], 200);
    check("post_rst_c1_x", got_x[1], 200);
    check("post_rst_c1_y", got_y[1], 600);
    check("post_rst_c2_x", got_x[2], 0);
    check("post_rst_c2_y", got_y[2], 800);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_filter.md
Name: sobel_window_filter

Overview:
- Streaming 3x3 Sobel convolution stage. Sits between the grayscale converter and the absolute-value/saturation stage of the image processing pipeline.
- Consumes one 12-bit grayscale pixel per valid cycle (raster order, 640 pixels/row). Produces signed horizontal (Gx) and vertical (Gy) gradients with a valid strobe, one output per accepted input.
- Buffers the two previous rows internally.

Parameters:
- WIDTH, 640, grayscale pixels per row (line-buffer depth, column counter modulus)
- DATA_W, 12, input pixel width (unsigned)
- OUT_W, 15, gradient width (signed two's complement)

Ports:
- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  reset, asynchronous, active-low
- iDATA  in  DATA_W  grayscale pixel, unsigned
- iDVAL  in  1  pixel valid, sampled on rising iCLK
- oSOBEL_X  out  OUT_W  signed Gx
- oSOBEL_Y  out  OUT_W  signed Gy
- oDVAL  out  1  gradient valid, one-cycle pulse per accepted input

Behaviour:
- Reset (iRST=0, asynchronous): oDVAL=0, oSOBEL_X=0, oSOBEL_Y=0. Column counter=0, rows_seen=0, window registers=0, pipeline valids=0. Line-buffer RAM is not cleared.
- Reset mid-row: all in-flight pixels are discarded. After release, the first accepted pixel is column 0 of row 0.
- Column counter increments on each accepted pixel (iDVAL=1). Wraps WIDTH-1 -> 0. On wrap, rows_seen increments and saturates at 2.
- iDVAL=0 cycles, including gaps mid-row: counter, window and line buffers hold. No output is generated.
- Line buffers: LB1 holds the previous row, LB2 the row before it. Both are addressed by the column counter, with read-before-write.
  - When a pixel is accepted: LB2[col] <= LB1[col], LB1[col] <= iDATA.
  - LB1 read data is forced to 0 while rows_seen<1. LB2 read data is forced to 0 while rows_seen<2. This emulates zero-initialised buffers.
- Window: 3x3 registers w[r][c], r=0 top (oldest row), r=2 bottom (current row), c=2 newest column.
  - On accept: columns shift left, and new column = {LB2 read, LB1 read, iDATA}.
  - If the accepted pixel has col==0, columns 0 and 1 load 0 instead of the shifted values (left-edge zero padding; no wrap-around from the previous row).
- Arithmetic, computed on the updated window, full precision, no saturation (results fit OUT_W):
  - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20)
  - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02)
  - Range ±4*(2^DATA_W - 1) = ±16380.
- Latency: exactly 2 cycles.
  - Stage 1 updates the window and registers the new column.
  - Stage 2 registers Gx/Gy.
  - Pixel sampled at edge N produces oDVAL=1 after edge N+2.
- Back-to-back inputs give back-to-back outputs; no stalls, no backpressure.
- oSOBEL_X/Y hold their last value while oDVAL=0.
- Column count is independent of upstream counters. Input rows longer than WIDTH wrap silently.

Decomposition:
- Shared package: WIDTH, DATA_W, OUT_W defaults; typedef for signed gradient; column-counter width constant $clog2(WIDTH).
- One sub-module: sobel_line_buffer. Single-port WIDTH x DATA_W RAM, read-before-write, synchronous read. Instantiated twice, or once with 2*DATA_W data width.
- Window, counters and arithmetic stay in the top module.

Test Plan:
- Reset check: hold iRST=0 for 5 cycles -> oDVAL=0, oSOBEL_X=0, oSOBEL_Y=0. Assert iRST=0 mid-row -> oDVAL=0 within the same cycle (asynchronous).
- Uniform 200, 4 rows x 640 -> exactly 2560 oDVAL pulses.
  - Row 0, col 5: Gx=0, Gy=+800.
  - Row 2 onward, col>=2: Gx=0, Gy=0.
- Left-edge padding, uniform 100, row 3:
  - col 0 -> Gx=+400
  - col 1 -> Gx=+400
  - col 2 -> Gx=0
  - all three Gy=0
- Vertical edge (cols<320 = 0, cols>=320 = 200), row 3:
  - col 320 -> Gx=+800
  - col 321 -> Gx=+800
  - col 322 -> Gx=0
  - Gy=0 throughout
- Horizontal edge (rows 0-1 = 255, rows 2-3 = 0), col 10:
  - row 2 -> Gy=-1020
  - row 3 -> Gy=-1020
  - row 4 (value 0) -> Gy=0
  - Gx=0 throughout
- Input gaps: insert 3-cycle iDVAL=0 gaps every 7 pixels in the vertical-edge stream -> gradient sequence identical to the gapless run. Each oDVAL arrives exactly 2 cycles after its iDVAL.
